axis_eth_fcs_strip_check: RTL and testbench

//  Receive-side counterpart of the Ethernet FCS generator. Takes an 8-bit AXI-Stream

---
 rtl/axis_eth_fcs_strip_check.sv | 104 ++++++++++
 tb/tb_axis_eth_fcs_strip_check.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_eth_fcs_strip_check.sv
// rtl/axis_eth_fcs_strip_check.sv - strips the 4-byte Ethernet FCS from an 8-bit stream and flags CRC-32 mismatches
module axis_eth_fcs_strip_check #(
  parameter logic USER_BAD_FRAME_VALUE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       error_bad_fcs,
  output logic       error_short_frame
);

  localparam logic [31:0] POLY_REFL = 32'hEDB88320;  // 32'h04C11DB7 bit-reversed

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  // dl[3] is the oldest byte, dl[0] the newest
  logic [3:0][7:0] dl;
  logic [2:0]      count;
  logic [31:0]     crc_state;
  logic            user_latch;

  logic        accept;
  logic        full;
  logic [31:0] crc_next;
  logic [31:0] rx_fcs;
  logic        fcs_mismatch;
  logic        frame_bad;

  assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign full          = (count == 3'd4);
  assign crc_next      = crc_step(crc_state, dl[3]);
  // On the last beat the three buffered FCS bytes plus the incoming one form the received FCS
  assign rx_fcs        = {s_axis_tdata, dl[0], dl[1], dl[2]};
  assign fcs_mismatch  = (~crc_next != rx_fcs);
  assign frame_bad     = fcs_mismatch | s_axis_tuser | user_latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      dl                <= '0;
      count             <= 3'd0;
      crc_state         <= 32'hFFFFFFFF;
      user_latch        <= 1'b0;
      m_axis_tdata      <= 8'd0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= 1'b0;
      error_bad_fcs     <= 1'b0;
      error_short_frame <= 1'b0;
    end else begin
      error_bad_fcs     <= 1'b0;
      error_short_frame <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        dl <= {dl[2:0], s_axis_tdata};
        if (full) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= dl[3];
          m_axis_tlast  <= s_axis_tlast;
          m_axis_tuser  <= s_axis_tlast ? (frame_bad ? USER_BAD_FRAME_VALUE : ~USER_BAD_FRAME_VALUE)
                                        : 1'b0;
        end
        if (s_axis_tlast) begin
          count      <= 3'd0;
          crc_state  <= 32'hFFFFFFFF;
          user_latch <= 1'b0;
          if (full) begin
            error_bad_fcs <= fcs_mismatch;
          end else begin
            error_short_frame <= 1'b1;
          end
        end else begin
          if (full) begin
            crc_state <= crc_next;
          end else begin
            count <= count + 3'd1;
          end
          if (s_axis_tuser) begin
            user_latch <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_eth_fcs_strip_check.sv
// tb/tb_axis_eth_fcs_strip_check.sv - frame-level checks of FCS stripping and validation against a scoreboard
module tb_axis_eth_fcs_strip_check;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       s_axis_tuser;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       error_bad_fcs;
  logic       error_short_frame;

  always #5 clk = ~clk;

  axis_eth_fcs_strip_check #(.USER_BAD_FRAME_VALUE(1'b1)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .error_bad_fcs     (error_bad_fcs),
    .error_short_frame (error_short_frame)
  );

  typedef struct {
    int         plen;
    logic [7:0] fcs_xor;
    int         user_idx;
    bit         short_f;
    bit         chain;
    bit         exp_user;
    int         exp_fcs_err;
    int         exp_short;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t      sb[$];
  vec_t       vecs[8];
  logic [7:0] short_bytes[4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};
  int         total = 0;
  int         bad = 0;
  int         fcs_seen = 0;
  int         short_seen = 0;
  int         fcs_exp = 0;
  int         short_exp = 0;
  bit         rand_ready = 0;
  bit         rand_valid = 0;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    bit acc;
    int n;
    if (rand_valid && $urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    acc = 0;
    n = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    if (!acc) chk("s_axis_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input vec_t v, input bit rnd);
    logic [7:0]  f[$];
    logic [7:0]  b;
    logic [31:0] c;
    beat_t       e;
    if (v.short_f) begin
      for (int i = 0; i < v.plen; i++) f.push_back(short_bytes[i]);
    end else begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < v.plen; i++) begin
        b = rnd ? 8'($urandom_range(0, 255)) : 8'(8'h31 + i);
        f.push_back(b);
        c = crc_byte(c, b);
        e.d = b;
        e.l = (i == v.plen - 1);
        e.u = (i == v.plen - 1) ? v.exp_user : 1'b0;
        sb.push_back(e);
      end
      c = ~c;
      // Known check value for "123456789" keeps the DUT's CRC independent of the bench's
      if (!rnd && v.plen == 9) c = 32'hCBF43926;
      f.push_back(c[7:0]);
      f.push_back(c[15:8]);
      f.push_back(c[23:16]);
      f.push_back(c[31:24] ^ v.fcs_xor);
    end
    fcs_exp   += v.exp_fcs_err;
    short_exp += v.exp_short;
    for (int i = 0; i < f.size(); i++) begin
      send_beat(f[i], i == f.size() - 1, i == v.user_idx);
    end
  endtask

  task automatic check_totals(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_drained"}, sb.size(), 0);
    chk({name, "_bad_fcs_pulses"}, fcs_seen, fcs_exp);
    chk({name, "_short_pulses"}, short_seen, short_exp);
  endtask

  initial begin
    beat_t e;
    vec_t  v;
    bit    corrupt;
    int    plen;

    rst = 1'b1;
    s_axis_tdata = 8'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    m_axis_tready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) begin
            chk("m_axis_unexpected_beat", {22'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 32'hFFFFFFFF);
          end else begin
            e = sb.pop_front();
            chk("m_axis_beat", {22'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser}, {22'd0, e});
          end
        end
        if (error_bad_fcs === 1'b1) fcs_seen++;
        if (error_short_frame === 1'b1) short_seen++;
      end
      forever begin
        @(posedge clk);
        #1;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      end
      begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    vecs[0] = '{9, 8'h00, -1, 0, 0, 0, 0, 0};
    vecs[1] = '{9, 8'h01, -1, 0, 0, 1, 1, 0};
    vecs[2] = '{4, 8'h00, -1, 1, 1, 0, 0, 1};
    vecs[3] = '{9, 8'h00, -1, 0, 0, 0, 0, 0};
    vecs[4] = '{9, 8'h00,  2, 0, 0, 1, 0, 0};
    vecs[5] = '{1, 8'h00, -1, 0, 0, 0, 0, 0};
    vecs[6] = '{1, 8'h00, -1, 1, 0, 0, 0, 1};
    vecs[7] = '{9, 8'h00, 12, 0, 0, 1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_m_axis_tvalid", m_axis_tvalid, 0);
    chk("reset_s_axis_tready", s_axis_tready, 1);
    chk("reset_m_axis_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 0);
    chk("reset_error_pulses", {error_bad_fcs, error_short_frame}, 0);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i], 0);
      if (!vecs[i].chain) check_totals($sformatf("vec%0d", i));
    end

    // Reset after the sixth byte: only the two already-released payload bytes may appear
    for (int i = 0; i < 2; i++) begin
      e.d = 8'(8'h31 + i);
      e.l = 1'b0;
      e.u = 1'b0;
      sb.push_back(e);
    end
    for (int i = 0; i < 6; i++) send_beat(8'(8'h31 + i), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_m_axis_tvalid", m_axis_tvalid, 0);
    chk("midreset_sb_empty", sb.size(), 0);
    send_frame(vecs[0], 0);
    check_totals("after_midreset");

    rand_ready = 1;
    rand_valid = 1;
    for (int k = 0; k < 100; k++) begin
      plen = (k == 0) ? 1518 : (k == 1) ? 5 : $urandom_range(5, 48);
      corrupt = ($urandom_range(0, 3) == 0);
      v = '{plen, corrupt ? 8'h5A : 8'h00, -1, 0, 0, corrupt, corrupt ? 1 : 0, 0};
      send_frame(v, 1);
    end
    check_totals("random");
    rand_ready = 0;
    m_axis_tready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
